// File: rtl/reg_write_arbiter.sv
// ============================================================================
// reg_write_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares one WIDTH-bit register among N_REQ requesters. A round-robin
//   arbiter picks one pending requester at a time. The owner is then walked
//   through a fixed four-state handshake: IDLE -> GRANT -> WRITE -> ACK.
//   Data is staged into D at the end of GRANT. It is committed to Q at the
//   end of WRITE, and the owner receives a one-cycle Ack in the ACK state.
//
// Parameters:
//   N_REQ  - number of requesters (2..8)
//   WIDTH  - width of the shared register
//
// Ports:
//   Clock   in   single clock; all state changes on its rising edge
//   Reset   in   asynchronous, active-low reset
//   Req     in   [N_REQ]        per-requester write request, held until Ack
//   WrData  in   [N_REQ*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   Grant   out  [N_REQ]        one-hot owner of the shared register
//   Ack     out  [N_REQ]        one-cycle completion pulse to the owner
//   Enable  out  1              write strobe, high only in WRITE
//   D       out  [WIDTH]        staged write data
//   Q       out  [WIDTH]        shared register contents
//   Qn      out  [WIDTH]        bitwise complement of Q
//   Busy    out  1              high whenever the FSM is not in IDLE
// ============================================================================
module reg_write_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic [N_REQ-1:0]       Req,
   input  logic [N_REQ*WIDTH-1:0] WrData,
   output logic [N_REQ-1:0]       Grant,
   output logic [N_REQ-1:0]       Ack,
   output logic                   Enable,
   output logic [WIDTH-1:0]       D,
   output logic [WIDTH-1:0]       Q,
   output logic [WIDTH-1:0]       Qn,
   output logic                   Busy
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WRITE = 2'd2,
      ACK   = 2'd3
   } state_t;

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   sel;
   logic [IW-1:0]   rr_pick;
   logic [IW-1:0]   ptr_next;
   logic [WIDTH-1:0] sel_data;

   // Round-robin search.
   // Scans upward from start, wrapping modulo N_REQ.
   // The first requesting index wins.
   // The result is only consumed when req is non-zero.
   function automatic logic [IW-1:0] rr_select(input logic [N_REQ-1:0] req,
                                               input logic [IW-1:0]    start);
      logic [IW-1:0] pick;
      logic          found;
      int            idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(start) + k) % N_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = IW'(idx);
         end
      end
      return pick;
   endfunction

   // Expand an index into a one-hot requester vector.
   function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Combinational helpers feeding the FSM.
   // They compute the next winner and the next pointer value.
   // They also pick out the data lane of the current owner.
   always_comb begin
      rr_pick  = rr_select(Req, ptr);
      ptr_next = (sel == IW'(N_REQ - 1)) ? '0 : sel + IW'(1);
      sel_data = WrData[int'(sel)*WIDTH +: WIDTH];
   end

   // Qn tracks Q continuously.
   // It therefore reads all-ones as soon as reset clears Q.
   assign Qn = ~Q;

   // Main handshake FSM.
   //
   // Every output except Qn is registered here, so each output changes
   // only on a clock edge (or on reset).
   //
   // A reset that arrives during WRITE wipes Q to zero; the staged data is
   // discarded rather than committed.
   //
   // If the owner drops its request while in GRANT, the transaction is
   // abandoned without touching the pointer. The same requester therefore
   // keeps its priority for the next arbitration.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state  <= IDLE;
         ptr    <= '0;
         sel    <= '0;
         Grant  <= '0;
         Ack    <= '0;
         Enable <= 1'b0;
         Busy   <= 1'b0;
         D      <= '0;
         Q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               Ack    <= '0;
               Enable <= 1'b0;
               if (|Req) begin
                  sel   <= rr_pick;
                  Grant <= onehot(rr_pick);
                  Busy  <= 1'b1;
                  state <= GRANT;
               end else begin
                  Grant <= '0;
                  Busy  <= 1'b0;
               end
            end

            GRANT: begin
               if (Req[sel]) begin
                  D      <= sel_data;
                  Enable <= 1'b1;
                  state  <= WRITE;
               end else begin
                  Grant  <= '0;
                  Busy   <= 1'b0;
                  state  <= IDLE;
               end
            end

            WRITE: begin
               Q      <= D;
               Enable <= 1'b0;
               Ack    <= onehot(sel);
               state  <= ACK;
            end

            ACK: begin
               Ack   <= '0;
               Grant <= '0;
               Busy  <= 1'b0;
               ptr   <= ptr_next;
               state <= IDLE;
            end

            default: begin
               Ack    <= '0;
               Grant  <= '0;
               Enable <= 1'b0;
               Busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
